// File: rtl/jk_flip_flop_pkg.sv
// Shared JK encodings and next-state rule for the JK flip-flop primitives.
// The operation is selected by the concatenation {J,K}.
`timescale 1ns/1ps
package jk_flip_flop_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  function automatic logic jk_next(input jk_op_e op, input logic q);
    logic nxt;
    nxt = q;
    case (op)
      JK_HOLD: nxt = q;
      JK_RST:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TGL:  nxt = ~q;
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_flip_flop_cell.sv
// Single-bit JK storage cell with asynchronous active-high reset.
`timescale 1ns/1ps
module jk_flip_flop_cell
  import jk_flip_flop_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = jk_next(jk_op_e'({j, k}), q_q);
  end

  // Reset is in the sensitivity list so it overrides any coincident clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_flip_flop.sv
// WIDTH independent JK flip-flops sharing one clock and asynchronous reset.
// Qnot is derived from Q so the two outputs can never disagree.
`timescale 1ns/1ps
module jk_flip_flop #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qnot
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_flip_flop_cell #(
      .RESET_VAL(RESET_VAL[gi])
    ) u_cell (
      .clk(Clk),
      .rst(Rst),
      .j  (J[gi]),
      .k  (K[gi]),
      .q  (Q[gi])
    );
  end

  assign Qnot = ~Q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed bench for jk_flip_flop: a 1-bit default instance and a 4-bit instance
// with a non-zero reset value, sharing clock and reset.
`timescale 1ns/100ps
module tb_jk_flip_flop;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [0:0] J = 1'b0, K = 1'b0;
  logic [0:0] Q, Qnot;
  logic [3:0] J4 = 4'b0000, K4 = 4'b0000;
  logic [3:0] Q4, Qnot4;

  int checks = 0;
  int errors = 0;

  always #1 Clk = ~Clk;  // 2 ns period, rising edges at 1, 3, 5, ...

  jk_flip_flop dut (
    .Clk(Clk), .Rst(Rst), .J(J), .K(K), .Q(Q), .Qnot(Qnot)
  );

  jk_flip_flop #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
    .Clk(Clk), .Rst(Rst), .J(J4), .K(K4), .Q(Q4), .Qnot(Qnot4)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic exp);
    chk({tag, "_q"},    {3'b000, Q[0]},    {3'b000, exp});
    chk({tag, "_qnot"}, {3'b000, Qnot[0]}, {3'b000, ~exp});
  endtask

  task automatic chk4(input string tag, input logic [3:0] exp);
    chk({tag, "_q4"},    Q4,    exp);
    chk({tag, "_qnot4"}, Qnot4, ~exp);
  endtask

  // Drive J/K at the falling edge, then sample just after the next rising edge.
  task automatic step(input logic j, input logic k, input logic [3:0] j4, input logic [3:0] k4);
    @(negedge Clk);
    J[0] = j; K[0] = k; J4 = j4; K4 = k4;
    @(posedge Clk);
    #0.2;
  endtask

  initial begin
    // Async reset mid-cycle while J=1,K=0
    J = 1'b1; K = 1'b0;
    @(posedge Clk);
    #0.5;
    Rst = 1'b1;
    #0.2;
    chk1("rst_async", 1'b0);
    chk4("rst_async", 4'b1010);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 4'b1111, 4'b0000);
      chk1("rst_held", 1'b0);
      chk4("rst_held", 4'b1010);
    end

    // Release at falling edge; Q holds reset value until the next rising edge
    @(negedge Clk);
    Rst = 1'b0; J = 1'b0; K = 1'b0; J4 = 4'b0000; K4 = 4'b0000;
    #0.5;
    chk1("rst_release", 1'b0);
    chk4("rst_release", 4'b1010);

    // Hold from 0
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 4'b0000, 4'b0000);
      chk1("hold0", 1'b0);
      chk4("hold_rv", 4'b1010);
    end

    // Set; the wide instance runs mixed per-bit ops (toggle, set, reset, hold)
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 4'b1100, 4'b1010);
      chk1("set", 1'b1);
      chk4("mixed", (i % 2 == 0) ? 4'b0100 : 4'b1100);
    end

    // Hold from 1
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 4'b0000, 4'b0000);
      chk1("hold1", 1'b1);
      chk4("hold_mixed", 4'b0100);
    end

    // Toggle from 1: 0,1,0,1,0
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 4'b1111, 4'b1111);
      chk1("toggle", (i % 2 == 0) ? 1'b0 : 1'b1);
      chk4("toggle4", (i % 2 == 0) ? 4'b1011 : 4'b0100);
    end

    // Reset op from 1
    step(1'b1, 1'b0, 4'b0000, 4'b0000);
    chk1("set_pre_rst", 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 4'b0000, 4'b1111);
      chk1("reset_op", 1'b0);
      chk4("reset_op4", 4'b0000);
    end

    // J/K pulse entirely between edges has no effect
    step(1'b1, 1'b0, 4'b1111, 4'b0000);
    chk1("set_pre_glitch", 1'b1);
    chk4("set_pre_glitch", 4'b1111);
    @(negedge Clk);
    J = 1'b0; K = 1'b1; J4 = 4'b0000; K4 = 4'b1111;
    #0.4;
    J = 1'b0; K = 1'b0; J4 = 4'b0000; K4 = 4'b0000;
    @(posedge Clk);
    #0.2;
    chk1("glitch", 1'b1);
    chk4("glitch", 4'b1111);

    // Async reset during toggling, then resume toggling from reset value
    step(1'b1, 1'b1, 4'b1111, 4'b1111);
    chk1("tgl_pre_rst", 1'b0);
    step(1'b1, 1'b1, 4'b1111, 4'b1111);
    chk1("tgl_pre_rst2", 1'b1);
    #0.3;
    Rst = 1'b1;
    #0.2;
    chk1("rst_in_toggle", 1'b0);
    chk4("rst_in_toggle", 4'b1010);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #0.2;
    chk1("tgl_after_rst", 1'b1);
    chk4("tgl_after_rst", 4'b0101);

    // Reset held across an edge beats J=1,K=0
    @(negedge Clk);
    Rst = 1'b1; J = 1'b1; K = 1'b0; J4 = 4'b0101; K4 = 4'b0000;
    @(posedge Clk);
    #0.2;
    chk1("rst_over_edge", 1'b0);
    chk4("rst_over_edge", 4'b1010);
    @(negedge Clk);
    Rst = 1'b0;
    step(1'b1, 1'b0, 4'b0101, 4'b0000);
    chk1("set_after_rst", 1'b1);
    chk4("set_after_rst", 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
